// File: rtl/pcm_i2s_tx_pkg.sv
// pcm_i2s_tx_pkg: shared frame geometry and divider sizing for the I2S transmitter
package pcm_i2s_tx_pkg;
  localparam int SLOT_BITS = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W = 6;
  function automatic int div_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction
endpackage

// File: rtl/pcm_i2s_tx_clkgen_bck_lrck_gen.sv
// bck_lrck_gen: MCLK divider producing BCK, LRCK, the bit position and the frame-load strobe
module bck_lrck_gen
  import pcm_i2s_tx_pkg::*;
#(
  parameter int BCK_DIV = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_bck,
  output logic                 o_lrck,
  output logic [BIT_CNT_W-1:0] o_bit_cnt,
  output logic                 o_bck_fall,
  output logic                 o_load
);
  localparam int DIV_W = div_cnt_w(BCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [BIT_CNT_W-1:0] r_bit, w_bit_nxt;
  logic r_bck, r_lrck, w_wrap;
  assign w_wrap = r_div == DIV_LAST;
  assign w_div_nxt = w_wrap ? '0 : r_div + 1'b1;
  assign w_bit_nxt = r_bit + 1'b1;
  // BCK is registered from the next divider value so it always matches div_cnt; bit/LRCK move on BCK falls
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_div <= '0;
      r_bit <= '0;
      r_bck <= 1'b0;
      r_lrck <= 1'b0;
    end else begin
      r_div <= w_div_nxt;
      r_bck <= w_div_nxt >= DIV_HALF;
      if (w_wrap) begin
        r_bit <= w_bit_nxt;
        r_lrck <= w_bit_nxt[BIT_CNT_W-1];
      end
    end
  assign o_bck = r_bck;
  assign o_lrck = r_lrck;
  assign o_bit_cnt = r_bit;
  assign o_bck_fall = w_wrap;
  assign o_load = w_wrap && (r_bit == '1);
endmodule

// File: rtl/pcm_i2s_tx_clkgen.sv
// pcm_i2s_tx_clkgen: I2S transmitter with one-pair holding buffer, MCLK-derived BCK/LRCK and sticky underrun
module pcm_i2s_tx_clkgen
  import pcm_i2s_tx_pkg::*;
#(
  parameter int PCM_BIT_WIDTH = 32,
  parameter int BCK_DIV = 2
) (
  input  logic                     MCLK_I,
  input  logic                     NRST_I,
  input  logic [PCM_BIT_WIDTH-1:0] DATAL_I,
  input  logic [PCM_BIT_WIDTH-1:0] DATAR_I,
  input  logic                     VALID_I,
  output logic                     READY_O,
  input  logic                     UNDERRUN_CLR_I,
  output logic                     MCLK_O,
  output logic                     BCK_O,
  output logic                     LRCK_O,
  output logic                     DATA_O,
  output logic                     UNDERRUN_O
);
  localparam int PAD = SLOT_BITS - PCM_BIT_WIDTH;
  logic [SLOT_BITS-1:0] w_slot_l, w_slot_r;
  logic [FRAME_BITS-1:0] r_hold, r_word;
  logic [BIT_CNT_W-1:0] w_bit;
  logic r_hold_full, r_ready, r_und, r_data;
  logic w_accept, w_load, w_bck_fall, w_hold_nxt;
  bck_lrck_gen #(.BCK_DIV(BCK_DIV)) u_gen (
    .i_clk      (MCLK_I),
    .i_rst_n    (NRST_I),
    .o_bck      (BCK_O),
    .o_lrck     (LRCK_O),
    .o_bit_cnt  (w_bit),
    .o_bck_fall (w_bck_fall),
    .o_load     (w_load)
  );
  assign w_slot_l = SLOT_BITS'(DATAL_I) << PAD;
  assign w_slot_r = SLOT_BITS'(DATAR_I) << PAD;
  assign w_accept = VALID_I & r_ready;
  assign w_hold_nxt = w_accept | (r_hold_full & ~w_load);
  // hold accepts a pair, frame load drains it (pre-edge state), serial bit k of the word goes out one BCK late
  always_ff @(posedge MCLK_I or negedge NRST_I)
    if (!NRST_I) begin
      r_hold <= '0;
      r_word <= '0;
      r_hold_full <= 1'b0;
      r_ready <= 1'b0;
      r_und <= 1'b0;
      r_data <= 1'b0;
    end else begin
      if (w_accept) r_hold <= {w_slot_l, w_slot_r};
      if (w_load) r_word <= r_hold_full ? r_hold : '0;
      r_hold_full <= w_hold_nxt;
      r_ready <= ~w_hold_nxt;
      r_und <= (w_load & ~r_hold_full) | (r_und & ~UNDERRUN_CLR_I);
      if (w_bck_fall) r_data <= r_word[~w_bit];
    end
  assign MCLK_O = MCLK_I;
  assign READY_O = r_ready;
  assign DATA_O = r_data;
  assign UNDERRUN_O = r_und;
endmodule

// File: tb/tb_pcm_i2s_tx_clkgen.sv
// tb_pcm_i2s_tx_clkgen: frame-level model of the I2S stream checked every MCLK, plus directed literal checks
module tb_pcm_i2s_tx_clkgen;
  localparam int DA = 2, FA = 64 * DA, DB = 8, FB = 64 * DB;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst_a = 1'b0, nrst_b = 1'b0;
  logic [31:0] la = '0, ra = '0;
  logic [15:0] lb = '0, rb = '0;
  logic va = 1'b0, clra = 1'b0, vb = 1'b0, clrb = 1'b0;
  logic ready_a, mclk_a, bck_a, lrck_a, data_a, und_a;
  logic ready_b, mclk_b, bck_b, lrck_b, data_b, und_b;
  int n_chk = 0, n_pass = 0;
  int ta, tb_t;
  // word sent in frame f lives at index f+1; index 0 stays zero (nothing before frame 0)
  logic [63:0] wa [16];
  logic [63:0] wb [16];

  pcm_i2s_tx_clkgen #(.PCM_BIT_WIDTH(32), .BCK_DIV(DA)) dut_a (
    .MCLK_I(clk), .NRST_I(nrst_a), .DATAL_I(la), .DATAR_I(ra), .VALID_I(va),
    .READY_O(ready_a), .UNDERRUN_CLR_I(clra), .MCLK_O(mclk_a), .BCK_O(bck_a),
    .LRCK_O(lrck_a), .DATA_O(data_a), .UNDERRUN_O(und_a));

  pcm_i2s_tx_clkgen #(.PCM_BIT_WIDTH(16), .BCK_DIV(DB)) dut_b (
    .MCLK_I(clk), .NRST_I(nrst_b), .DATAL_I(lb), .DATAR_I(rb), .VALID_I(vb),
    .READY_O(ready_b), .UNDERRUN_CLR_I(clrb), .MCLK_O(mclk_b), .BCK_O(bck_b),
    .LRCK_O(lrck_b), .DATA_O(data_b), .UNDERRUN_O(und_b));

  // MCLK edges since reset release for each instance
  always @(posedge clk or negedge nrst_a) if (!nrst_a) ta <= 0; else ta <= ta + 1;
  always @(posedge clk or negedge nrst_b) if (!nrst_b) tb_t <= 0; else tb_t <= tb_t + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // I2S: bit position 0 repeats the previous frame's last right bit, positions 1..63 walk the word MSB first
  function automatic logic exp_data(input int n, input logic [63:0] cur, input logic [63:0] prev);
    return (n == 0) ? prev[0] : cur[64-n];
  endfunction

  always @(negedge clk) begin
    int f, n;
    if (nrst_a) begin
      f = ta / FA;
      n = (ta / DA) % 64;
      chk("a_mclk", mclk_a, clk);
      chk("a_bck", bck_a, (ta % DA) >= DA / 2);
      chk("a_lrck", lrck_a, n >= 32);
      chk("a_data", data_a, exp_data(n, wa[f+1], wa[f]));
    end
    if (nrst_b) begin
      f = tb_t / FB;
      n = (tb_t / DB) % 64;
      chk("b_bck", bck_b, (tb_t % DB) >= DB / 2);
      chk("b_lrck", lrck_b, n >= 32);
      chk("b_data", data_b, exp_data(n, wb[f+1], wb[f]));
    end
  end

  task automatic wait_a(input int target);
    for (int k = 0; k < 4000 && ta < target; k++) @(negedge clk);
    chk("a_wait_t", ta, target);
  endtask

  task automatic wait_b(input int target);
    for (int k = 0; k < 4000 && tb_t < target; k++) @(negedge clk);
    chk("b_wait_t", tb_t, target);
  endtask

  // a pair accepted on edge e belongs to frame e/F + 1
  task automatic send_a(input logic [31:0] l, input logic [31:0] r);
    la = l; ra = r; va = 1'b1;
    for (int k = 0; k < 1000 && !ready_a; k++) @(negedge clk);
    chk("a_ready_before_accept", ready_a, 1);
    wa[(ta + 1) / FA + 2] = {l, r};
    @(negedge clk);
    chk("a_ready_after_accept", ready_a, 0);
  endtask

  task automatic send_b(input logic [15:0] l, input logic [15:0] r);
    lb = l; rb = r; vb = 1'b1;
    for (int k = 0; k < 1000 && !ready_b; k++) @(negedge clk);
    chk("b_ready_before_accept", ready_b, 1);
    wb[(tb_t + 1) / FB + 2] = {l, 16'h0, r, 16'h0};
    @(negedge clk);
    chk("b_ready_after_accept", ready_b, 0);
  endtask

  task automatic scen_a();
    logic [63:0] cap, lr;
    send_a(32'h80000001, 32'h7FFFFFFE);
    va = 1'b0;
    chk("a_model_word_f1", wa[2], 64'h80000001_7FFFFFFE);
    wait_a(FA + DA);
    for (int i = 0; i < 64; i++) begin
      cap = {cap[62:0], data_a};
      lr = {lr[62:0], lrck_a};
      repeat (DA) @(negedge clk);
    end
    chk("a_serial_frame1", cap, 64'h80000001_7FFFFFFE);
    chk("a_lrck_frame1", lr, 64'h00000001_FFFFFFFE);
    chk("a_und_after_empty_frame", und_a, 1);
    wait_a(3 * FA - 1);
    clra = 1'b1;
    @(negedge clk);
    clra = 1'b0;
    chk("a_und_clr_vs_new_underrun", und_a, 1);
    send_a(32'h12345678, 32'h9ABCDEF0);
    clra = 1'b1;
    @(negedge clk);
    clra = 1'b0;
    chk("a_und_cleared", und_a, 0);
    send_a(32'hFFFF0000, 32'h0000FFFF);
    send_a(32'hDEADBEEF, 32'h01000000);
    va = 1'b0;
    send_a(32'h55555555, 32'hAAAAAAAA);
    va = 1'b0;
    chk("a_no_underrun_burst", und_a, 0);
    wait_a(6 * FA + 40 * DA);
    chk("a_lrck_before_reset", lrck_a, 1);
    chk("a_data_before_reset", data_a, 1);
    #2 nrst_a = 1'b0;
    #1;
    chk("a_rst_ready", ready_a, 0);
    chk("a_rst_bck", bck_a, 0);
    chk("a_rst_lrck", lrck_a, 0);
    chk("a_rst_data", data_a, 0);
    chk("a_rst_und", und_a, 0);
    for (int i = 0; i < 16; i++) wa[i] = '0;
    repeat (3) @(negedge clk);
    nrst_a = 1'b1;
    @(negedge clk);
    chk("a_ready_after_release", ready_a, 1);
    wait_a(FA - 1);
    chk("a_und_first_frame", und_a, 0);
    wait_a(FA + 1);
    chk("a_und_frame1_empty", und_a, 1);
  endtask

  task automatic scen_b();
    logic [63:0] cap;
    logic [7:0] bk;
    logic prev;
    int r1, r2;
    send_b(16'hA5A5, 16'h0001);
    vb = 1'b0;
    chk("b_model_slots", wb[2], 64'hA5A50000_00010000);
    wait_b(FB);
    for (int i = 0; i < 8; i++) begin
      bk = {bk[6:0], bck_b};
      @(negedge clk);
    end
    chk("b_bck_4_low_4_high", bk, 8'h0F);
    wait_b(FB + DB);
    for (int i = 0; i < 64; i++) begin
      cap = {cap[62:0], data_b};
      repeat (DB) @(negedge clk);
    end
    chk("b_serial_frame1", cap, 64'hA5A50000_00010000);
    r1 = -1; r2 = -1; prev = lrck_b;
    for (int k = 0; k < 2000 && r2 < 0; k++) begin
      @(negedge clk);
      if (lrck_b && !prev) begin
        if (r1 < 0) r1 = tb_t; else r2 = tb_t;
      end
      prev = lrck_b;
    end
    chk("b_lrck_period", r2 - r1, 512);
    chk("b_und_after_empty_frames", und_b, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      wa[i] = '0;
      wb[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("a_reset_ready", ready_a, 0);
    chk("a_reset_bck", bck_a, 0);
    chk("a_reset_lrck", lrck_a, 0);
    chk("a_reset_data", data_a, 0);
    chk("a_reset_und", und_a, 0);
    chk("b_reset_ready", ready_b, 0);
    nrst_a = 1'b1;
    nrst_b = 1'b1;
    @(negedge clk);
    chk("a_ready_first_edge", ready_a, 1);
    chk("b_ready_first_edge", ready_b, 1);
    chk("a_und_idle", und_a, 0);
    fork
      scen_a();
      scen_b();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
